// File: rtl/button_encoder_pkg.sv
// Shared types and constants for the button-driven byte encoder.
package button_encoder_pkg;

  localparam int unsigned NUM_BUTTONS = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned NIBBLE_W    = 4;

  localparam int unsigned BTN_INC_LO = 0;
  localparam int unsigned BTN_INC_HI = 1;
  localparam int unsigned BTN_CLEAR  = 2;
  localparam int unsigned BTN_COMMIT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Increment each nibble independently, modulo 16, with no carry between them.
  function automatic logic [BYTE_W-1:0] inc_nibbles(input logic [BYTE_W-1:0] value,
                                                     input logic            inc_lo,
                                                     input logic            inc_hi);
    logic [NIBBLE_W-1:0] hi;
    logic [NIBBLE_W-1:0] lo;
    hi = value[BYTE_W-1:NIBBLE_W] + NIBBLE_W'(inc_hi);
    lo = value[NIBBLE_W-1:0] + NIBBLE_W'(inc_lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, stability counter and rising-edge press strobe.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: count consecutive disagreeing cycles; accept the new level once it has held long enough.
  always_comb begin
    meta_d   = btn_raw;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
      press_d  = sync_q;  // only the rising transition produces a press
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/button_byte_encoder.sv
// Builds a byte from four debounced buttons and publishes it on a commit press.
module button_byte_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clockIn,
  input  logic                   resetN,
  input  logic [NUM_BUTTONS-1:0] controlButtons,
  output logic [BYTE_W-1:0]      workingByte,
  output logic [BYTE_W-1:0]      committedByte,
  output logic                   byteValid,
  output logic                   editing
);

  logic [NUM_BUTTONS-1:0] btn_stable;
  logic [NUM_BUTTONS-1:0] btn_press_raw;
  logic [NUM_BUTTONS-1:0] btn_press;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] working_q, working_d;
  logic [BYTE_W-1:0] committed_q, committed_d;
  logic              valid_q, valid_d;
  logic              editing_q, editing_d;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clockIn),
      .rst_n  (resetN),
      .btn_raw(controlButtons[i]),
      .stable (btn_stable[i]),
      .press  (btn_press_raw[i])
    );
  end

  // A press strobe always coincides with the debounced level going high.
  assign btn_press = btn_press_raw & btn_stable;

  // Next-state and datapath: clear beats commit beats increments; COMMIT ignores all presses.
  always_comb begin
    state_d     = state_q;
    working_d   = working_q;
    committed_d = committed_q;
    valid_d     = 1'b0;
    unique case (state_q)
      IDLE, EDIT: begin
        if (btn_press[BTN_CLEAR]) begin
          working_d = '0;
          state_d   = IDLE;
        end else if (btn_press[BTN_COMMIT]) begin
          state_d = COMMIT;
        end else if (btn_press[BTN_INC_LO] || btn_press[BTN_INC_HI]) begin
          working_d = inc_nibbles(working_q, btn_press[BTN_INC_LO], btn_press[BTN_INC_HI]);
          state_d   = EDIT;
        end
      end
      COMMIT: begin
        committed_d = working_q;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    editing_d = (state_d == EDIT);
  end

  // State and output registers.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      working_q   <= '0;
      committed_q <= '0;
      valid_q     <= 1'b0;
      editing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      working_q   <= working_d;
      committed_q <= committed_d;
      valid_q     <= valid_d;
      editing_q   <= editing_d;
    end
  end

  assign workingByte   = working_q;
  assign committedByte = committed_q;
  assign byteValid     = valid_q;
  assign editing       = editing_q;

endmodule

// File: tb/tb_button_byte_encoder.sv
// Randomized scoreboard bench for button_byte_encoder with a fast debounce setting.
module tb_button_byte_encoder;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [7:0] wb;
  logic [7:0] cb;
  logic       bv;
  logic       ed;

  button_byte_encoder #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clockIn       (clk),
    .resetN        (rst_n),
    .controlButtons(btn),
    .workingByte   (wb),
    .committedByte (cb),
    .byteValid     (bv),
    .editing       (ed)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         m_work = 0;
  logic       m_edit = 1'b0;
  logic       bv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: the effect of one debounced press set, priority clear > commit > increments.
  task automatic model_apply(input logic [3:0] m);
    int hi;
    int lo;
    if (m[2]) begin
      m_work = 0;
      m_edit = 1'b0;
    end else if (m[3]) begin
      exp_q.push_back(8'(m_work));
      m_edit = 1'b0;
    end else if (m[1:0] != 2'b00) begin
      hi     = (m_work / 16 + int'(m[1])) % 16;
      lo     = (m_work % 16 + int'(m[0])) % 16;
      m_work = hi * 16 + lo;
      m_edit = 1'b1;
    end
  endtask

  // Clean press: hold 8 cycles, release 8 cycles, then compare against the model.
  task automatic press(input logic [3:0] m, input string name);
    model_apply(m);
    btn = m;
    tick(8);
    btn = 4'b0000;
    tick(8);
    check({name, " workingByte"}, 32'(wb), 32'(m_work));
    check({name, " editing"}, 32'(ed), 32'(m_edit));
  endtask

  // Monitor: every byteValid pops one expected committed byte.
  always @(negedge clk) begin
    if (bv === 1'b1) begin
      check("byteValid width", 32'(bv_prev), 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected byteValid: committedByte 0x%0h with nothing committed", cb);
      end else begin
        check("committedByte", 32'(cb), 32'(exp_q.pop_front()));
      end
    end
    bv_prev <= bv;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time (%0d vectors)", n_vec);
    $fatal(1);
  end

  initial begin
    btn   = 4'b0000;
    rst_n = 1'b0;
    tick(3);
    check("reset workingByte", 32'(wb), 32'h00);
    check("reset committedByte", 32'(cb), 32'h00);
    check("reset byteValid", 32'(bv), 32'd0);
    check("reset editing", 32'(ed), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: latency of a single clean press
    btn = 4'b0001;
    tick(DEB + 2);
    check("t1 before edit", 32'(wb), 32'h00);
    tick(1);
    check("t1 after edit", 32'(wb), 32'h01);
    check("t1 editing", 32'(ed), 32'd1);
    m_work = 1;
    m_edit = 1'b1;
    btn = 4'b0000;
    tick(10);

    // 2: nibble wrap without carry
    press(4'b0100, "t2 clear");
    for (int i = 0; i < 17; i++) press(4'b0010, "t2 inc_hi");
    for (int i = 0; i < 16; i++) press(4'b0001, "t2 inc_lo");
    check("t2 final", 32'(wb), 32'h10);

    // 3: build 0x3A and commit
    press(4'b0100, "t3 clear");
    for (int i = 0; i < 3; i++) press(4'b0011, "t3 inc_both");
    for (int i = 0; i < 7; i++) press(4'b0001, "t3 inc_lo");
    press(4'b1000, "t3 commit");
    check("t3 workingByte kept", 32'(wb), 32'h3A);
    check("t3 committedByte", 32'(cb), 32'h3A);

    // 4: short glitches on inc-high never register
    press(4'b0100, "t4 clear");
    begin
      int cyc = 0;
      while (cyc < 50) begin
        int hi_len = $urandom_range(1, DEB - 1);
        int lo_len = $urandom_range(1, 3);
        btn = 4'b0010;
        tick(hi_len);
        btn = 4'b0000;
        tick(lo_len);
        cyc += hi_len + lo_len;
      end
    end
    tick(10);
    check("t4 workingByte", 32'(wb), 32'h00);
    check("t4 editing", 32'(ed), 32'd0);

    // 5: simultaneous presses
    for (int i = 0; i < 5; i++) press(4'b0011, "t5 build");
    check("t5 built", 32'(wb), 32'h55);
    press(4'b1101, "t5 clear+commit+inc");
    press(4'b0011, "t5 inc_both");
    check("t5 final", 32'(wb), 32'h11);

    // 6: reset during EDIT with a held button
    press(4'b0100, "t6 clear");
    for (int i = 0; i < 7; i++) press(4'b0011, "t6 inc_both");
    for (int i = 0; i < 5; i++) press(4'b0001, "t6 inc_lo");
    check("t6 built", 32'(wb), 32'h7C);
    btn = 4'b0001;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async workingByte", 32'(wb), 32'h00);
    check("t6 async committedByte", 32'(cb), 32'h00);
    check("t6 async editing", 32'(ed), 32'd0);
    m_work = 0;
    m_edit = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(DEB + 2);
    check("t6 before edit", 32'(wb), 32'h00);
    tick(1);
    check("t6 after edit", 32'(wb), 32'h01);
    check("t6 editing", 32'(ed), 32'd1);
    m_work = 1;
    m_edit = 1'b1;
    btn = 4'b0000;
    tick(10);

    // Random press sets against the model
    for (int i = 0; i < 60; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      press(m, "rand");
    end

    tick(5);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_byte_encoder.md
Name: button_byte_encoder

Overview:
Input-side counterpart to the byte display path. Instead of showing an 8-bit value, this block lets the user build one with the four control buttons.
- Each button is synchronized, debounced and edge-detected.
- Presses edit two 4-bit nibbles of a working byte.
- A commit press publishes the byte with a one-cycle valid strobe, for the display/decoder path or other consumers.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a button state change is accepted (10 ms at 100 MHz); must be >= 2.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
clockIn  input  1  system clock; the only clock.
resetN  input  1  asynchronous, active-low reset.
controlButtons  input  4  raw asynchronous buttons, active-high: [0]=inc low nibble, [1]=inc high nibble, [2]=clear, [3]=commit.
workingByte  output  8  byte currently being edited.
committedByte  output  8  last committed byte.
byteValid  output  1  one-cycle pulse when committedByte updates.
editing  output  1  high while state is EDIT.

Behaviour:
- Reset: async assert on resetN=0; release is synchronous to clockIn. Reset values:
  - workingByte=0, committedByte=0, byteValid=0, editing=0, state=IDLE.
  - All synchronizer flops, stable states and debounce counters = 0.
- Per button:
  - 2-flop synchronizer produces sync.
  - The counter clears whenever sync==stable.
  - When sync!=stable the counter increments; when it reaches DEBOUNCE_CYCLES-1 and sync still differs, stable<=sync and the counter clears.
  - press = stable rising edge, one-cycle pulse.
  - Release edges generate nothing.
- Latency: a clean press held from cycle 0 produces its press pulse in cycle DEBOUNCE_CYCLES+2. Edits become visible on the outputs one cycle later (registered).
- Glitches: a bounce shorter than DEBOUNCE_CYCLES cycles produces no press and restarts the count.
- States: IDLE, EDIT, COMMIT (encoding in package).
  - IDLE: inc press -> apply the increment, go to EDIT. Commit press -> COMMIT. Clear press -> workingByte=0, stay IDLE.
  - EDIT: inc press -> apply the increment, stay. Clear -> workingByte=0, go to IDLE. Commit -> COMMIT.
  - COMMIT (one cycle): committedByte<=workingByte, byteValid=1, then IDLE. All press pulses arriving in this cycle are discarded. workingByte is retained.
- Arithmetic:
  - Each nibble increments modulo 16 independently: F+1=0, with no carry into the high nibble.
- Simultaneous presses in one cycle, priority clear > commit > increments:
  - Clear plus anything: only the clear acts.
  - Commit plus inc: the commit acts, and the inc is dropped.
  - inc-low plus inc-high together: both nibbles increment in the same cycle.
- byteValid: high for exactly one cycle per commit. It is never high two consecutive cycles, since COMMIT always returns to IDLE.
- Reset mid-operation: everything returns to reset values immediately. A button held across reset release is seen as a new press after DEBOUNCE_CYCLES+2 cycles.
- Held button: exactly one press per debounced assertion; no auto-repeat.

Decomposition:
- Package button_encoder_pkg:
  - state enum (IDLE, EDIT, COMMIT);
  - button index constants (BTN_INC_LO=0, BTN_INC_HI=1, BTN_CLEAR=2, BTN_COMMIT=3);
  - NUM_BUTTONS=4.
- Sub-module button_debouncer: synchronizer + counter + edge detect, with outputs stable and press. It is instantiated NUM_BUTTONS times via generate.
- The FSM and datapath stay in the top level.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4.
1. Reset then hold button[0] for 10 cycles -> press in cycle 6; workingByte=0x01 in cycle 7; editing=1; byteValid never asserts.
2. Press inc-high 17 times, then inc-low 16 times, each held 8 cycles and released 8 cycles -> workingByte=0x10, showing the wrap with no carry.
3. Build 0x3A, then press commit -> byteValid high exactly one cycle; committedByte=0x3A; editing=0; workingByte stays 0x3A.
4. Toggle button[1] with 1-3 cycle glitches for 50 cycles -> workingByte stays 0x00; no press.
5. Assert clear+commit+inc-low on the same cycle with workingByte=0x55 -> workingByte=0x00, state IDLE, no byteValid. Then inc-low+inc-high together on the same cycle -> 0x11.
6. Drive resetN low for 2 cycles in mid-EDIT with workingByte=0x7C while button[0] is held -> all outputs 0 asynchronously. After release, one press appears at cycle 6 and workingByte=0x01.
